// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, rs/rt field positions,
// fetch FSM states and the skid buffer entry layout.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_t;

    // One fetched word together with the PC+4 that belongs to it
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } skid_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry skid buffer holding an instruction and its npc while decode
// is stalled. clear wins over load; unload empties the entry.
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  skid_entry_t din,
    output skid_entry_t dout,
    output logic        full
);

    // Entry storage and occupancy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register. Owns the PC, fetches over a
// req/ack handshake, parks one word in a skid buffer when decode stalls and
// redirects on taken branches (branch > stall > fetch).
// Optional build macro FETCH_STATS_EN adds fetched/bubble counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_npc,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_bubbles,
`endif
    output logic [4:0]  IR_rs,
    output logic [4:0]  IR_rt
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_plus4;
    logic         redirect, bubble, cap_fetch, cap_skid, pc_adv;
    logic         skid_load, skid_unload, skid_full;
    skid_entry_t  skid_din, skid_dout;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // Request is withdrawn while reset is held even though state is S_FETCH
    assign imem_req  = (state == S_FETCH) && rst_n;
    assign IR_rs     = id_ir[RS_MSB:RS_LSB];
    assign IR_rt     = id_ir[RT_MSB:RT_LSB];
    assign skid_din  = '{ir: imem_rdata, npc: pc_plus4};

    fetch_skid u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect),
        .din    (skid_din),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_n;
    end

    // Next state and datapath controls; a redirect overrides everything,
    // including a word acked in the same cycle
    always_comb begin
        state_n     = state;
        redirect    = 1'b0;
        bubble      = 1'b0;
        cap_fetch   = 1'b0;
        cap_skid    = 1'b0;
        pc_adv      = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (branch_taken) begin
            redirect = 1'b1;
            state_n  = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_adv = 1'b1;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_n   = S_HOLD;
                        end else begin
                            cap_fetch = 1'b1;
                        end
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall && skid_full) begin
                        cap_skid    = 1'b1;
                        skid_unload = 1'b1;
                        state_n     = S_FETCH;
                    end else if (!stall) begin
                        state_n = S_FETCH;
                    end
                end
                default: state_n = S_FETCH;
            endcase
        end
    end

    // PC and IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_ir    <= NOP_INSTR;
            id_npc   <= 32'h0;
        end else begin
            if (redirect)    pc <= {branch_target[31:2], 2'b00};
            else if (pc_adv) pc <= pc_plus4;

            if (redirect || bubble) begin
                id_valid <= 1'b0;
                id_ir    <= NOP_INSTR;
            end else if (cap_fetch) begin
                id_valid <= 1'b1;
                id_ir    <= imem_rdata;
                id_npc   <= pc_plus4;
            end else if (cap_skid) begin
                id_valid <= 1'b1;
                id_ir    <= skid_dout.ir;
                id_npc   <= skid_dout.npc;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Counters for instructions written into IF/ID and unstalled bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= 32'h0;
            stat_bubbles <= 32'h0;
        end else begin
            if (cap_fetch || cap_skid)              stat_fetched <= stat_fetched + 32'd1;
            if ((redirect || bubble) && !stall)     stat_bubbles <= stat_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, stall/skid,
// branch with simultaneous ack, ack bubbles, PC wrap and reset in S_HOLD.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, ack_en;
    logic [31:0] branch_target;
    logic        imem_req, imem_ack, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_ir, id_npc;
    logic [4:0]  IR_rs, IR_rt;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_bubbles;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instruction memory: acks on demand, word at 0 is lw $2,4($1),
    // every other address returns a tagged pattern
    assign imem_ack   = ack_en;
    assign imem_rdata = (imem_addr == 32'h0) ? 32'h8C22_0004 : (32'hA000_0000 ^ imem_addr);

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ir         (id_ir),
        .id_npc        (id_npc),
`ifdef FETCH_STATS_EN
        .stat_fetched  (stat_fetched),
        .stat_bubbles  (stat_bubbles),
`endif
        .IR_rs         (IR_rs),
        .IR_rt         (IR_rt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] ir, input logic [31:0] npc);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, v});
        chk({tag, ".ir"}, id_ir, ir);
        chk({tag, ".npc"}, id_npc, npc);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; ack_en = 1'b1;
        #3;
        chk("rst.req", {31'h0, imem_req}, 32'h0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_id("rst", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run.req", {31'h0, imem_req}, 32'h1);

        // First fetch lands after edge 1
        step();
        chk_id("f0", 1'b1, 32'h8C22_0004, 32'h4);
        chk("f0.rs", {27'h0, IR_rs}, 32'd1);
        chk("f0.rt", {27'h0, IR_rt}, 32'd2);
        chk("f0.addr", imem_addr, 32'h4);

        // Stall 3 cycles: word @4 parks in skid, IF/ID frozen, no request
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_id("stall", 1'b1, 32'h8C22_0004, 32'h4);
            chk("stall.req", {31'h0, imem_req}, 32'h0);
            chk("stall.addr", imem_addr, 32'h8);
        end
        stall = 1'b0;
        step();
        chk_id("unskid", 1'b1, 32'hA000_0004, 32'h8);
        chk("unskid.req", {31'h0, imem_req}, 32'h1);
        step();
        chk_id("f8", 1'b1, 32'hA000_0008, 32'hC);

        // Branch with simultaneous ack and stall: branch wins
        branch_taken = 1'b1; branch_target = 32'h0000_0103; stall = 1'b1;
        step();
        chk_id("br", 1'b0, 32'h0, 32'hC);
        chk("br.addr", imem_addr, 32'h100);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        chk_id("tgt", 1'b1, 32'hA000_0100, 32'h104);

        // Two cycles without ack: two bubbles
        ack_en = 1'b0;
        step();
        chk_id("bub1", 1'b0, 32'h0, 32'h104);
        chk("bub1.addr", imem_addr, 32'h104);
        step();
        chk_id("bub2", 1'b0, 32'h0, 32'h104);
`ifdef FETCH_STATS_EN
        chk("stat.bubbles", stat_bubbles, 32'd2);
`endif
        ack_en = 1'b1;
        step();
        chk_id("f104", 1'b1, 32'hA000_0104, 32'h108);
`ifdef FETCH_STATS_EN
        chk("stat.fetched", stat_fetched, 32'd5);
`endif

        // PC wrap at the top of the address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step();
        chk_id("wrap", 1'b1, 32'h5FFF_FFFC, 32'h0);
        chk("wrap.addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
        chk("wrap.bubbles", stat_bubbles, 32'd3);
        chk("wrap.fetched", stat_fetched, 32'd6);
`endif

        // Reset pulsed while in S_HOLD acts without a clock edge
        stall = 1'b1;
        step();
        chk("hold.req", {31'h0, imem_req}, 32'h0);
        chk("hold.addr", imem_addr, 32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk_id("arst", 1'b0, 32'h0, 32'h0);
        chk("arst.addr", imem_addr, 32'h0);
        chk("arst.req", {31'h0, imem_req}, 32'h0);
`ifdef FETCH_STATS_EN
        chk("arst.fetched", stat_fetched, 32'h0);
`endif
        #1 rst_n = 1'b1;
        stall = 1'b0; ack_en = 1'b0;
        // Skid was cleared, so no stale word may be unloaded here
        step();
        chk_id("post", 1'b0, 32'h0, 32'h0);
        ack_en = 1'b1;
        step();
        chk_id("post.f0", 1'b1, 32'h8C22_0004, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
